// File: rtl/shit_fall_ctrl_if.sv
// shit_fall_ctrl_if: frame/drop/collision inputs and position/status outputs of the falling-object controller.
interface shit_fall_ctrl_if;
    logic startOfFrame;
    logic drop;
    logic collision;
    logic signed [10:0] dropX;
    logic signed [10:0] dropY;
    logic signed [7:0] windSpeed;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic isActive;
    logic splash;
    logic busy;
    modport master(
        output startOfFrame, drop, collision, dropX, dropY, windSpeed,
        input topLeftX, topLeftY, isActive, splash, busy
    );
    modport slave(
        input startOfFrame, drop, collision, dropX, dropY, windSpeed,
        output topLeftX, topLeftY, isActive, splash, busy
    );
endinterface

// File: rtl/shit_fall_ctrl.sv
// shit_fall_ctrl: gravity-driven falling object with floor landing, collision splash and timed return to idle.
// Horizontal wind drift is built in only when SHIT_FALL_WIND_EN is defined.
module shit_fall_ctrl #(
    parameter logic signed [10:0] FLOOR_Y = 11'sd447,
    parameter int GRAVITY = 4,
    parameter int MAX_SPEED = 512,
    parameter int SPLASH_FRAMES = 8
) (
    input logic clk,
    input logic resetN,
    shit_fall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FALL, SPLASH} state_t;
    state_t state, state_n;
    logic [15:0] speed, speed_n, spd_add, spd_new;
    logic signed [16:0] pos_x, pos_x_n, pos_y, pos_y_n, x_new;
    logic signed [17:0] y_add;
    logic [7:0] cnt, cnt_n;
    logic landed, spl_done;

    assign spd_add = speed + 16'(GRAVITY);
    assign spd_new = (spd_add > 16'(MAX_SPEED)) ? 16'(MAX_SPEED) : spd_add;
    assign y_add = {pos_y[16], pos_y} + {2'b00, spd_new};
    assign landed = $signed(y_add[17:6]) >= $signed({FLOOR_Y[10], FLOOR_Y});
    assign spl_done = cnt == 8'(SPLASH_FRAMES - 1);

`ifdef SHIT_FALL_WIND_EN
    logic signed [17:0] x_sum;
    assign x_sum = {pos_x[16], pos_x} + {{4{bus.windSpeed[7]}}, bus.windSpeed, 6'b0};
    assign x_new = (x_sum < 0) ? '0 : (x_sum > 18'sd40896) ? 17'sd40896 : x_sum[16:0];
`else
    logic unused_wind;
    assign unused_wind = ^bus.windSpeed;
    assign x_new = pos_x;
`endif

    always_comb begin
        state_n = state;
        speed_n = speed;
        pos_x_n = pos_x;
        pos_y_n = pos_y;
        cnt_n = cnt;
        case (state)
            IDLE: if (bus.drop) begin
                state_n = FALL;
                speed_n = '0;
                pos_x_n = {bus.dropX, 6'b0};
                pos_y_n = {bus.dropY, 6'b0};
            end
            FALL: begin
                // a collision freezes motion unless this same frame also lands
                if (bus.startOfFrame && (landed || !bus.collision)) begin
                    speed_n = spd_new;
                    pos_x_n = x_new;
                    pos_y_n = landed ? {FLOOR_Y, 6'b0} : y_add[16:0];
                end
                if (bus.collision || (bus.startOfFrame && landed)) state_n = SPLASH;
            end
            SPLASH: if (bus.startOfFrame) begin
                cnt_n = spl_done ? '0 : cnt + 8'd1;
                state_n = spl_done ? IDLE : SPLASH;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state <= IDLE;
            speed <= '0;
            pos_x <= '0;
            pos_y <= '0;
            cnt <= '0;
            bus.topLeftX <= '0;
            bus.topLeftY <= '0;
            bus.isActive <= 1'b0;
            bus.splash <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            state <= state_n;
            speed <= speed_n;
            pos_x <= pos_x_n;
            pos_y <= pos_y_n;
            cnt <= cnt_n;
            bus.topLeftX <= pos_x_n[16:6];
            bus.topLeftY <= pos_y_n[16:6];
            bus.isActive <= state_n != IDLE;
            bus.splash <= state_n == SPLASH;
            bus.busy <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_shit_fall_ctrl.sv
// tb_shit_fall_ctrl: directed scenarios checked every cycle against a frame-level behavioural model.
module tb_shit_fall_ctrl;
    localparam int FLOOR = 447, G = 4, VMAX = 512, NSPL = 8;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    int checks = 0;
    int failures = 0;
    bit run = 1'b0;
    int m_phase, m_x, m_y, m_v, m_left, v, ny;
    bit land;

    shit_fall_ctrl_if bus();
    shit_fall_ctrl dut(.clk(clk), .resetN(resetN), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int wind(input int x);
        int r;
        r = x;
`ifdef SHIT_FALL_WIND_EN
        r = x + int'(bus.windSpeed) * 64;
        if (r < 0) r = 0;
        if (r > 639 * 64) r = 639 * 64;
`endif
        return r;
    endfunction

    // model: phase 0 idle, 1 falling, 2 splashing; positions in 1/64 px
    always @(posedge clk) begin
        if (!resetN) begin
            m_phase = 0; m_x = 0; m_y = 0; m_v = 0; m_left = 0;
        end else if (m_phase == 0) begin
            if (bus.drop) begin
                m_phase = 1; m_x = int'(bus.dropX) * 64; m_y = int'(bus.dropY) * 64; m_v = 0;
            end
        end else if (m_phase == 1) begin
            land = 1'b0;
            if (bus.startOfFrame) begin
                v = (m_v + G > VMAX) ? VMAX : m_v + G;
                ny = m_y + v;
                land = (ny >>> 6) >= FLOOR;
                if (land || !bus.collision) begin
                    m_v = v; m_y = land ? FLOOR * 64 : ny; m_x = wind(m_x);
                end
            end
            if (land || bus.collision) begin
                m_phase = 2; m_left = NSPL;
            end
        end else if (bus.startOfFrame) begin
            m_left--;
            if (m_left == 0) m_phase = 0;
        end
    end

    always @(negedge clk) if (run) begin
        chk("isActive", int'(bus.isActive), int'(m_phase != 0));
        chk("splash", int'(bus.splash), int'(m_phase == 2));
        chk("busy", int'(bus.busy), int'(m_phase != 0));
        chk("topLeftX", int'(bus.topLeftX), m_x >>> 6);
        chk("topLeftY", int'(bus.topLeftY), m_y >>> 6);
    end

    task automatic step(input logic s, input logic d, input logic c);
        bus.startOfFrame = s; bus.drop = d; bus.collision = c;
        @(negedge clk);
        bus.startOfFrame = 1'b0; bus.drop = 1'b0; bus.collision = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_active"}, int'(bus.isActive), 0);
        chk({tag, "_splash"}, int'(bus.splash), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_x"}, int'(bus.topLeftX), 0);
        chk({tag, "_y"}, int'(bus.topLeftY), 0);
    endtask

    initial begin
        int n;
        bus.startOfFrame = 1'b0; bus.drop = 1'b0; bus.collision = 1'b0;
        bus.dropX = '0; bus.dropY = '0; bus.windSpeed = '0;
        @(negedge clk);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        run = 1'b1;
        chk_zero("reset");
        resetN = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        chk("idle_collision_ignored", int'(bus.isActive), 0);
        bus.dropX = 11'sd100; bus.dropY = 11'sd0;
        step(1'b0, 1'b1, 1'b0);
        chk("drop_active", int'(bus.isActive), 1);
        chk("drop_splash", int'(bus.splash), 0);
        chk("drop_x", int'(bus.topLeftX), 100);
        chk("drop_y", int'(bus.topLeftY), 0);
        frames(4);
        chk("fall4_y", int'(bus.topLeftY), 0);
        frames(12);
        chk("fall16_y", int'(bus.topLeftY), 8);
        step(1'b0, 1'b0, 1'b1);
        chk("coll_splash", int'(bus.splash), 1);
        chk("coll_y", int'(bus.topLeftY), 8);
        frames(8);
        chk("coll_done", int'(bus.isActive), 0);
        // drop coinciding with a frame pulse: no motion until the next pulse
        bus.dropX = 11'sd20; bus.dropY = 11'sd440;
        step(1'b1, 1'b1, 1'b0);
        chk("sof_drop_active", int'(bus.isActive), 1);
        chk("sof_drop_y", int'(bus.topLeftY), 440);
        n = 0;
        while (!bus.splash && n < 40) begin
            frames(1);
            n++;
        end
        chk("land_within_bound", int'(bus.splash), 1);
        chk("land_frames", n, 15);
        chk("land_y", int'(bus.topLeftY), 447);
        frames(7);
        chk("splash7_active", int'(bus.isActive), 1);
        frames(1);
        chk("splash8_active", int'(bus.isActive), 0);
        chk("splash8_splash", int'(bus.splash), 0);
        bus.dropX = 11'sd50; bus.dropY = 11'sd196;
        step(1'b0, 1'b1, 1'b0);
        frames(11);
        chk("mid_y", int'(bus.topLeftY), 200);
        step(1'b0, 1'b0, 1'b1);
        chk("mid_coll_splash", int'(bus.splash), 1);
        chk("mid_coll_y", int'(bus.topLeftY), 200);
        bus.dropX = 11'sd300;
        step(1'b0, 1'b1, 1'b0);
        chk("busy_drop_x", int'(bus.topLeftX), 50);
        chk("busy_drop_splash", int'(bus.splash), 1);
        frames(2);
        resetN = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        chk_zero("midreset");
        resetN = 1'b1;
        frames(2);
        chk("release_splash", int'(bus.splash), 0);
        bus.dropX = 11'sd10; bus.dropY = 11'sd20;
        step(1'b0, 1'b1, 1'b0);
        chk("restart_active", int'(bus.isActive), 1);
        chk("restart_x", int'(bus.topLeftX), 10);
        chk("restart_y", int'(bus.topLeftY), 20);
        step(1'b0, 1'b0, 1'b1);
        frames(8);
        bus.windSpeed = -8'sd3; bus.dropX = 11'sd4; bus.dropY = 11'sd0;
        step(1'b0, 1'b1, 1'b0);
        frames(2);
`ifdef SHIT_FALL_WIND_EN
        chk("wind_x", int'(bus.topLeftX), 0);
`else
        chk("wind_x", int'(bus.topLeftX), 4);
`endif
        bus.windSpeed = '0;
        step(1'b0, 1'b0, 1'b0);
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shit_fall_ctrl.md
SHIT_FALL_CTRL -- requirements
Module: shit_fall_ctrl

Interface
REQ-001 Parameter FLOOR_Y, default 11'sd447: screen Y (pixels) at which a falling object is considered landed.
REQ-002 Parameter GRAVITY, default 4: per-frame speed increment, fixed-point (1/64 px per frame).
REQ-003 Parameter MAX_SPEED, default 512: speed ceiling, fixed-point (1/64 px per frame).
REQ-004 Parameter SPLASH_FRAMES, default 8: number of frames the splash state is held.
REQ-005 clk  in  1  system clock.
REQ-006 resetN  in  1  reset, synchronous, active-low.
REQ-007 startOfFrame  in  1  one-cycle pulse, once per video frame.
REQ-008 drop  in  1  one-cycle request to launch a new object.
REQ-009 dropX, dropY  in  11 signed each  launch top-left position, in pixels.
REQ-010 collision  in  1  level signal: the object hit a target.
REQ-011 windSpeed  in  8 signed  horizontal drift, in pixels per frame.
REQ-012 topLeftX, topLeftY  out  11 signed each  current object top-left position, in pixels.
REQ-013 isActive  out  1  object is alive, in either the FALL or the SPLASH state.
REQ-014 splash  out  1  object is in the SPLASH state.
REQ-015 busy  out  1  equal to isActive; indicates that drop is ignored.

Function
REQ-016 FSM states SHALL be IDLE, FALL and SPLASH; all outputs SHALL be registered.
REQ-017 IDLE, drop=1: the block SHALL latch posX=dropX<<6, posY=dropY<<6 and speed=0, and enter FALL on the next cycle.
REQ-018 FALL, on each startOfFrame: speed SHALL become min(speed+GRAVITY, MAX_SPEED), then posY SHALL increase by the new speed.
REQ-019 Internal position SHALL be 17-bit signed fixed point (6 fractional bits); topLeftY = posY>>>6 and topLeftX = posX>>>6, arithmetic shift.
REQ-020 FALL, when the updated posY>>>6 >= FLOOR_Y: topLeftY SHALL clamp to FLOOR_Y and the FSM SHALL enter SPLASH on the same startOfFrame update.
REQ-021 FALL, collision=1 on any cycle: the FSM SHALL enter SPLASH on the next cycle and the position SHALL freeze.
REQ-022 Collision and floor landing in the same cycle: the block SHALL enter SPLASH once, at the clamped Y.
REQ-023 SPLASH: the position SHALL hold and a frame counter SHALL count startOfFrame pulses.
REQ-024 SPLASH: after SPLASH_FRAMES pulses the FSM SHALL return to IDLE and isActive SHALL go to 0.
REQ-025 drop while isActive=1 SHALL be ignored, with no restart and no queuing.
REQ-026 collision in IDLE or SPLASH SHALL be ignored.
REQ-027 drop and startOfFrame in the same cycle in IDLE: the drop SHALL be accepted, and the first motion SHALL occur on the next startOfFrame.
REQ-028 Output latency from any state change to isActive/splash SHALL be exactly 1 clk.

Reset
REQ-029 With resetN=0 at a clk edge: state=IDLE, speed=0, posX=posY=0, frame counter=0, all outputs 0.
REQ-030 Reset asserted mid-FALL or mid-SPLASH SHALL abort the object; no splash SHALL be emitted after reset release.

Configuration
REQ-031 Macro SHIT_FALL_WIND_EN, when defined: in FALL, each startOfFrame SHALL add windSpeed<<6 to posX, saturating at 0 and 639 pixels.
REQ-032 Macro SHIT_FALL_WIND_EN, when undefined: windSpeed SHALL be ignored, posX SHALL stay constant from drop, and the port SHALL remain present.

Verification
REQ-033 Scenario: reset, then drop with dropX=100, dropY=0 -> next cycle isActive=1, splash=0, topLeftX=100, topLeftY=0.
REQ-034 Scenario: default parameters, 4 startOfFrame pulses after drop -> speed 4,8,12,16; posY=40 (fixed point), topLeftY=0; after 16 frames topLeftY=8.
REQ-035 Scenario: dropY=440, frames applied until landing -> topLeftY=447 and splash=1; 8 frames later isActive=0.
REQ-036 Scenario: collision pulse mid-FALL at topLeftY=200 -> splash=1 next cycle with topLeftY held at 200; a second drop during SPLASH is ignored.
REQ-037 Scenario: resetN=0 during SPLASH -> all outputs 0 the next cycle; a new drop after release starts cleanly.
REQ-038 Scenario, SHIT_FALL_WIND_EN defined: windSpeed=-3, dropX=4, 2 frames -> topLeftX=0 (saturated); with the macro undefined, topLeftX stays 4.
